// File: rtl/param_calculator.sv
// Multi-cycle unsigned calculator: add/sub in one cycle, shift-add multiply and restoring divide over WIDTH cycles.
// Optional remainder output is built only when CALC_REMAINDER_EN is defined; otherwise Rem is tied to zero.
module param_calculator #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             SCEN,
    input  logic             ButU,
    input  logic             ButD,
    input  logic             ButR,
    input  logic             ButL,
    input  logic [WIDTH-1:0] In,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] Rem,
    output logic             Flag,
    output logic             Busy,
    output logic             Done,
    output logic [6:0]       State
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [6:0] S_INITIAL = 7'b0000001;
    localparam logic [6:0] S_GET_A   = 7'b0000010;
    localparam logic [6:0] S_GET_B   = 7'b0000100;
    localparam logic [6:0] S_GET_OP  = 7'b0001000;
    localparam logic [6:0] S_COMPUTE = 7'b0010000;
    localparam logic [6:0] S_ERR     = 7'b0100000;
    localparam logic [6:0] S_DONE    = 7'b1000000;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [6:0]         state_r;
    logic [6:0]         next_state_s;
    logic [1:0]         op_sel_s;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [WIDTH-1:0]   rw_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   c_r;
    logic               flag_r;

    logic               last_s;
    logic               enter_compute_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] prod_next_s;
    logic [WIDTH:0]     rw_shift_s;
    logic               ge_s;
    logic [WIDTH-1:0]   rw_next_s;
    logic [WIDTH-1:0]   quo_next_s;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= S_INITIAL;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Button priority decode: U (mul) > D (div) > R (add) > L (sub)
    always_comb begin
        op_sel_s = OP_SUB;
        if (ButU) begin
            op_sel_s = OP_MUL;
        end else if (ButD) begin
            op_sel_s = OP_DIV;
        end else if (ButR) begin
            op_sel_s = OP_ADD;
        end else begin
            op_sel_s = OP_SUB;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_INITIAL: next_state_s = SCEN ? S_GET_A : S_INITIAL;
            S_GET_A:   next_state_s = SCEN ? S_GET_B : S_GET_A;
            S_GET_B:   next_state_s = SCEN ? S_GET_OP : S_GET_B;
            S_GET_OP: begin
                if (ButU) begin
                    next_state_s = S_COMPUTE;
                end else if (ButD) begin
                    next_state_s = (b_r == {WIDTH{1'b0}}) ? S_ERR : S_COMPUTE;
                end else if (ButR || ButL) begin
                    next_state_s = S_COMPUTE;
                end else begin
                    next_state_s = S_GET_OP;
                end
            end
            S_COMPUTE: begin
                if ((op_r == OP_ADD) || (op_r == OP_SUB)) begin
                    next_state_s = S_DONE;
                end else if (last_s) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_COMPUTE;
                end
            end
            S_DONE:    next_state_s = SCEN ? S_INITIAL : S_DONE;
            S_ERR:     next_state_s = SCEN ? S_INITIAL : S_ERR;
            default:   next_state_s = S_INITIAL;
        endcase
    end

    // State-derived outputs; all are decodes of the registered one-hot state
    always_comb begin
        State = state_r;
        Busy  = (state_r == S_COMPUTE);
        Done  = (state_r == S_DONE);
    end

    // Per-iteration arithmetic for all four operations
    always_comb begin
        last_s          = (cnt_r == CNT_LAST);
        enter_compute_s = (state_r == S_GET_OP) && (next_state_s == S_COMPUTE);
        sum_s           = {1'b0, a_r} + {1'b0, b_r};
        prod_next_s     = prod_r;
        if (b_r[cnt_r]) begin
            prod_next_s = prod_r + ({{WIDTH{1'b0}}, a_r} << cnt_r);
        end else begin
            prod_next_s = prod_r;
        end
        // Partial remainder never exceeds 2*B-1, so one extra bit is enough for the compare
        rw_shift_s = {rw_r, quo_r[WIDTH-1]};
        ge_s       = (rw_shift_s >= {1'b0, b_r});
        if (ge_s) begin
            rw_next_s = rw_shift_s[WIDTH-1:0] - b_r;
        end else begin
            rw_next_s = rw_shift_s[WIDTH-1:0];
        end
        quo_next_s = {quo_r[WIDTH-2:0], ge_s};
    end

    // Operand capture, iterative datapath and result registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            op_r   <= OP_ADD;
            cnt_r  <= {CNT_W{1'b0}};
            prod_r <= {(2*WIDTH){1'b0}};
            rw_r   <= {WIDTH{1'b0}};
            quo_r  <= {WIDTH{1'b0}};
            c_r    <= {WIDTH{1'b0}};
            flag_r <= 1'b0;
        end else begin
            case (state_r)
                S_GET_A: if (SCEN) a_r <= In;
                S_GET_B: if (SCEN) b_r <= In;
                S_GET_OP: begin
                    if (enter_compute_s) begin
                        op_r   <= op_sel_s;
                        cnt_r  <= {CNT_W{1'b0}};
                        prod_r <= {(2*WIDTH){1'b0}};
                        rw_r   <= {WIDTH{1'b0}};
                        quo_r  <= a_r;
                        c_r    <= {WIDTH{1'b0}};
                        flag_r <= 1'b0;
                    end
                end
                S_COMPUTE: begin
                    case (op_r)
                        OP_ADD: begin
                            c_r    <= sum_s[WIDTH-1:0];
                            flag_r <= sum_s[WIDTH];
                        end
                        OP_SUB: begin
                            c_r    <= a_r - b_r;
                            flag_r <= (a_r < b_r);
                        end
                        OP_MUL: begin
                            prod_r <= prod_next_s;
                            if (last_s) begin
                                c_r    <= prod_next_s[WIDTH-1:0];
                                flag_r <= |prod_next_s[2*WIDTH-1:WIDTH];
                            end
                        end
                        OP_DIV: begin
                            rw_r  <= rw_next_s;
                            quo_r <= quo_next_s;
                            if (last_s) begin
                                c_r    <= quo_next_s;
                                flag_r <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                    cnt_r <= (next_state_s == S_COMPUTE) ? (cnt_r + CNT_ONE) : {CNT_W{1'b0}};
                end
                default: ;
            endcase
        end
    end

    assign C    = c_r;
    assign Flag = flag_r;

`ifdef CALC_REMAINDER_EN
    logic [WIDTH-1:0] rem_r;

    // Remainder register: cleared on COMPUTE entry, loaded on the final divide iteration
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rem_r <= {WIDTH{1'b0}};
        end else if (enter_compute_s) begin
            rem_r <= {WIDTH{1'b0}};
        end else if ((state_r == S_COMPUTE) && (op_r == OP_DIV) && last_s) begin
            rem_r <= rw_next_s;
        end else begin
            rem_r <= rem_r;
        end
    end

    assign Rem = rem_r;
`else
    assign Rem = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_param_calculator.sv
// Scoreboard bench for param_calculator: expected results queued at op issue, checked when Done rises.
module tb_param_calculator;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] c;
        logic [W-1:0] rem;
        logic         flag;
    } exp_t;

    logic         Clk;
    logic         Reset;
    logic         SCEN;
    logic         ButU, ButD, ButR, ButL;
    logic [W-1:0] In;
    logic [W-1:0] C;
    logic [W-1:0] Rem;
    logic         Flag, Busy, Done;
    logic [6:0]   State;

    exp_t sb_q[$];
    exp_t last_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    param_calculator #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .SCEN(SCEN),
        .ButU(ButU), .ButD(ButD), .ButR(ButR), .ButL(ButL),
        .In(In), .C(C), .Rem(Rem), .Flag(Flag),
        .Busy(Busy), .Done(Done), .State(State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_scen();
        SCEN = 1'b1;
        tick();
        SCEN = 1'b0;
    endtask

    function automatic exp_t model(input logic [3:0] btn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W:0]     s;
        exp_t           e;
        e = '0;
        if (btn[3]) begin
            p      = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.c    = p[W-1:0];
            e.flag = (p[2*W-1:W] != {W{1'b0}});
        end else if (btn[2]) begin
            e.c = a / b;
`ifdef CALC_REMAINDER_EN
            e.rem = a % b;
`endif
        end else if (btn[1]) begin
            s      = {1'b0, a} + {1'b0, b};
            e.c    = s[W-1:0];
            e.flag = s[W];
        end else begin
            e.c    = a - b;
            e.flag = (a < b);
        end
        return e;
    endfunction

    // Walk INITIAL -> GET_A -> GET_B -> GET_OP, probing that stray inputs are ignored
    task automatic enter_operands(input logic [W-1:0] a, input logic [W-1:0] b);
        chk("st_initial", State, 7'b0000001);
        pulse_scen();
        chk("st_get_a", State, 7'b0000010);
        ButU = 1'b1;
        tick();
        ButU = 1'b0;
        chk("btn_ignored_get_a", State, 7'b0000010);
        In = a;
        pulse_scen();
        chk("st_get_b", State, 7'b0000100);
        In = b;
        pulse_scen();
        In = ~b;
        chk("st_get_op", State, 7'b0001000);
        pulse_scen();
        chk("scen_ignored_get_op", State, 7'b0001000);
    endtask

    task automatic fire(input logic [3:0] btn, input logic [W-1:0] a, input logic [W-1:0] b);
        int   lat;
        int   busy_n;
        int   exp_lat;
        exp_t got;
        exp_lat = (btn[3] || btn[2]) ? (W + 1) : 2;
        {ButU, ButD, ButR, ButL} = btn;
        sb_q.push_back(model(btn, a, b));
        tick();
        {ButU, ButD, ButR, ButL} = 4'b0000;
        lat    = 1;
        busy_n = 0;
        while (!Done && lat < 40) begin
            if (Busy) busy_n++;
            tick();
            lat++;
        end
        chk("done_reached", Done, 1'b1);
        chk("latency", lat, exp_lat);
        chk("busy_cycles", busy_n, (btn[3] || btn[2]) ? W : 1);
        chk("busy_in_done", Busy, 1'b0);
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            chk("result_c", C, got.c);
            chk("result_rem", Rem, got.rem);
            chk("result_flag", Flag, got.flag);
            last_e = got;
        end
        pulse_scen();
        chk("done_to_initial", State, 7'b0000001);
    endtask

    task automatic run_op(input logic [3:0] btn, input logic [W-1:0] a, input logic [W-1:0] b);
        enter_operands(a, b);
        fire(btn, a, b);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [3:0]   rbtn;
        Reset = 1'b1;
        SCEN  = 1'b0;
        {ButU, ButD, ButR, ButL} = 4'b0000;
        In    = {W{1'b0}};
        last_e = '0;
        tick();
        tick();
        chk("rst_state", State, 7'b0000001);
        chk("rst_c", C, 16'h0000);
        chk("rst_rem", Rem, 16'h0000);
        chk("rst_flag", Flag, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        Reset = 1'b0;
        tick();
        chk("idle_hold", State, 7'b0000001);

        run_op(4'b0010, 16'hFFFF, 16'h0002);
        chk("plan_add_c", C, 16'h0001);
        chk("plan_add_flag", Flag, 1'b1);
        run_op(4'b0001, 16'd3, 16'd5);
        chk("plan_sub_c", C, 16'hFFFE);
        run_op(4'b0001, 16'd5, 16'd3);
        chk("plan_sub_c2", C, 16'h0002);
        run_op(4'b1000, 16'd300, 16'd300);
        chk("plan_mul_c", C, 16'h5F90);
        chk("plan_mul_flag", Flag, 1'b1);
        run_op(4'b1000, 16'd255, 16'd257);
        chk("plan_mul_c2", C, 16'hFFFF);
        run_op(4'b0100, 16'd100, 16'd7);
        chk("plan_div_c", C, 16'd14);
`ifdef CALC_REMAINDER_EN
        chk("plan_div_rem", Rem, 16'd2);
`else
        chk("plan_div_rem", Rem, 16'd0);
`endif
        run_op(4'b1100, 16'd1234, 16'd56);
        run_op(4'b0011, 16'h8000, 16'h8000);
        run_op(4'b0100, 16'd5, 16'd9);

        // Divide by zero: ERR next cycle, results untouched
        enter_operands(16'd9, 16'd0);
        ButD = 1'b1;
        tick();
        ButD = 1'b0;
        chk("dz_state", State, 7'b0100000);
        chk("dz_busy", Busy, 1'b0);
        chk("dz_c", C, last_e.c);
        chk("dz_rem", Rem, last_e.rem);
        chk("dz_flag", Flag, last_e.flag);
        tick();
        chk("dz_hold", State, 7'b0100000);
        chk("dz_busy2", Busy, 1'b0);
        pulse_scen();
        chk("dz_to_initial", State, 7'b0000001);

        // Reset asserted in the fifth COMPUTE cycle of a multiply
        enter_operands(16'd300, 16'd300);
        ButU = 1'b1;
        tick();
        ButU = 1'b0;
        repeat (4) tick();
        chk("mid_busy", Busy, 1'b1);
        #2 Reset = 1'b1;
        #1;
        chk("async_state", State, 7'b0000001);
        chk("async_c", C, 16'h0000);
        chk("async_rem", Rem, 16'h0000);
        chk("async_flag", Flag, 1'b0);
        chk("async_busy", Busy, 1'b0);
        chk("async_done", Done, 1'b0);
        #1 Reset = 1'b0;
        tick();
        run_op(4'b0010, 16'd1000, 16'd2345);

        for (int i = 0; i < 8; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbtn = 4'b0001 << $urandom_range(0, 3);
            if (rbtn[2] && rb == {W{1'b0}}) rb = 16'd1;
            run_op(rbtn, ra, rb);
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_calculator.md
# param_calculator

Parametrised, multi-cycle integer calculator for the board-level calculator design. The operator enters two WIDTH-bit operands and selects add, subtract, multiply or divide with push-buttons. Add and subtract complete in one cycle. Multiply (shift-add) and divide (restoring) are iterative and take WIDTH cycles each. The block reports the result, an overflow/borrow flag, a divide-by-zero error and one-hot state outputs for LED debug.

## Interface
- WIDTH, 16: operand and result width in bits; must be ≥ 2.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- SCEN  in  1  confirm pulse, one cycle wide, from the upstream debouncer.
- ButU / ButD / ButR / ButL  in  1 each  op-select pulses: multiply / divide / add / subtract.
- In  in  WIDTH  operand input from switches.
- C  out  WIDTH  result: sum, difference, low product half, or quotient.
- Rem  out  WIDTH  division remainder; see Configuration.
- Flag  out  1  overflow or borrow indicator.
- Busy  out  1  high while in COMPUTE.
- Done  out  1  high while in DONE.
- State  out  7  one-hot state; bit0 INITIAL, bit1 GET_A, bit2 GET_B, bit3 GET_OP, bit4 COMPUTE, bit5 ERR, bit6 DONE.

## Operation
- States and transitions:
  - INITIAL: on SCEN, go to GET_A.
  - GET_A: on SCEN, capture A ← In and go to GET_B.
  - GET_B: on SCEN, capture B ← In and go to GET_OP.
  - GET_OP: button priority is U > D > R > L. ButD with B == 0 goes to ERR. Any other accepted button latches the op and goes to COMPUTE.
  - COMPUTE: runs the latched op, then goes to DONE.
  - DONE: on SCEN, go to INITIAL.
  - ERR: on SCEN, go to INITIAL.
- Input filtering:
  - Buttons are ignored outside GET_OP.
  - SCEN is ignored in GET_OP and COMPUTE.
  - With no input, every state holds.
- On entry to COMPUTE, C, Rem and Flag clear to 0. They then hold their values through DONE, ERR, INITIAL and operand entry until the next COMPUTE.
- ADD: C = (A+B)[WIDTH-1:0]; Flag = carry out.
- SUB: C = (A−B) mod 2^WIDTH; Flag = 1 iff A < B.
- MUL:
  - Unsigned shift-add into a 2·WIDTH-bit accumulator, with a counter running WIDTH iterations.
  - C = product[WIDTH-1:0].
  - Flag = 1 iff product[2·WIDTH-1:WIDTH] ≠ 0.
- DIV:
  - Unsigned restoring division, WIDTH iterations.
  - C = A / B; Rem = A mod B; Flag = 0.
- ERR leaves C, Rem and Flag at their previous values.
- All arithmetic is unsigned.
- Reset:
  - Asserting Reset at any time, including mid-COMPUTE, aborts the operation.
  - Reset forces State = INITIAL (7'b0000001), C = 0, Rem = 0, Flag = 0, Busy = 0, Done = 0, A = 0, B = 0, and the iteration counter to 0.

## Timing
- Let t be the cycle in which an op button is sampled in GET_OP.
- ADD/SUB: COMPUTE at t+1; DONE with valid outputs at t+2.
- MUL/DIV:
  - COMPUTE spans t+1 … t+WIDTH.
  - DONE with valid outputs at t+WIDTH+1.
  - The iteration counter counts 0 … WIDTH−1 and resets to 0 on exit from COMPUTE.
- Divide by zero: State = ERR at t+1; Busy is never asserted.
- A SCEN sampled in DONE or ERR at cycle u gives State = INITIAL at u+1.
- Operands are sampled in the same cycle as the SCEN that advances the state; A and B are stable during COMPUTE.
- Simultaneous buttons: only the highest-priority one takes effect; the others are dropped.
- Busy, Done and State are registered and change only on a clock edge, except under Reset.

## Configuration
- CALC_REMAINDER_EN defined:
  - The remainder register is built.
  - Rem carries A mod B after DIV.
  - Rem is 0 after the other ops.
- CALC_REMAINDER_EN undefined:
  - No remainder register is built; Rem is tied to 0.
  - The DIV quotient datapath is unchanged and C is still valid.

## Test plan
- ADD, WIDTH=16: A=16'hFFFF, B=16'h0002, ButR → DONE at t+2, C=16'h0001, Flag=1, Busy high at t+1 only.
- SUB: A=3, B=5, ButL → C=16'hFFFE, Flag=1. Then A=5, B=3, ButL → C=2, Flag=0.
- MUL: A=300, B=300, ButU → Busy for 16 cycles, DONE at t+17, C=16'h5F90, Flag=1. Then A=255, B=257 → C=16'hFFFF, Flag=0.
- DIV: A=100, B=7, ButD → DONE at t+17, C=14, Rem=2 with CALC_REMAINDER_EN and Rem=0 without it. With ButD and ButU pulsed in the same cycle → MUL is executed.
- Divide by zero: A=9, B=0, ButD → ERR at t+1, Busy never high, C/Rem/Flag unchanged. SCEN → INITIAL next cycle.
- Reset mid-MUL: assert Reset at COMPUTE cycle 5 → State=7'b0000001 and C=Rem=Flag=Busy=Done=0 immediately (asynchronous). After release, a full ADD sequence completes normally.
